alarm_ring_ctrl: RTL and testbench

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

---
 rtl/alarm_ring_ctrl.sv | 176 +++++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: arms on a BCD target time, rings, snoozes and auto-silences.
// Reports the BCD time remaining to the alarm while armed.
module alarm_ring_ctrl #(
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       alarma_on,
  input  logic       apagar_alarma,
  input  logic       snooze,
  input  logic [7:0] HRTC,
  input  logic [7:0] MRTC,
  input  logic [7:0] SRTC,
  input  logic [7:0] HAL,
  input  logic [7:0] MAL,
  input  logic [7:0] SAL,
  output logic       activring,
  output logic [3:0] hora_1,
  output logic [3:0] hora_2,
  output logic [3:0] min_1,
  output logic [3:0] min_2,
  output logic [3:0] seg_1,
  output logic [3:0] seg_2,
  output logic [1:0] estado,
  output logic [3:0] snooze_left,
  output logic       missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZED = 2'b11
  } state_t;

  localparam logic [15:0] RING_LIM = 16'(RING_TIMEOUT_S);
  localparam logic [15:0] SNZ_LIM  = 16'(SNOOZE_S);
  localparam logic [3:0]  SNZ_MAX  = 4'(MAX_SNOOZE);

  state_t      state, state_n;
  logic [23:0] target, target_n;
  logic [15:0] ring_t, ring_t_n;
  logic [15:0] snz_t, snz_t_n;
  logic [3:0]  snz_left_n;
  logic        missed_n;
  logic [23:0] rem, rem_n;
  logic [23:0] now;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // (tgt - cur) mod 24h, digit by digit with borrow; hours go through binary.
  function automatic logic [23:0] bcd_remaining(input logic [23:0] tgt, input logic [23:0] cur);
    logic [4:0] su, st, mu, mt;
    logic [7:0] th, ch, hd;
    logic [3:0] ht, hu;
    logic       b;
    su = {1'b0, tgt[3:0]} - {1'b0, cur[3:0]};
    b  = su[4];
    if (b) su = su + 5'd10;
    st = {1'b0, tgt[7:4]} - {1'b0, cur[7:4]} - {4'd0, b};
    b  = st[4];
    if (b) st = st + 5'd6;
    mu = {1'b0, tgt[11:8]} - {1'b0, cur[11:8]} - {4'd0, b};
    b  = mu[4];
    if (b) mu = mu + 5'd10;
    mt = {1'b0, tgt[15:12]} - {1'b0, cur[15:12]} - {4'd0, b};
    b  = mt[4];
    if (b) mt = mt + 5'd6;
    th = {4'd0, tgt[23:20]} * 8'd10 + {4'd0, tgt[19:16]};
    ch = {4'd0, cur[23:20]} * 8'd10 + {4'd0, cur[19:16]};
    hd = th - ch - {7'd0, b};
    if (hd[7]) hd = hd + 8'd24;
    if (hd >= 8'd20) begin
      ht = 4'd2;
      hu = 4'(hd - 8'd20);
    end else if (hd >= 8'd10) begin
      ht = 4'd1;
      hu = 4'(hd - 8'd10);
    end else begin
      ht = 4'd0;
      hu = hd[3:0];
    end
    return {ht, hu, mt[3:0], mu[3:0], st[3:0], su[3:0]};
  endfunction

  assign now = {HRTC, MRTC, SRTC};

  always_comb begin
    state_n    = state;
    target_n   = target;
    ring_t_n   = ring_t;
    snz_t_n    = snz_t;
    snz_left_n = snooze_left;
    missed_n   = missed;
    if (!alarma_on) begin
      // missed survives disarming so it can still be read; a new arm clears it
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          target_n   = {HAL, MAL, SAL};
          snz_left_n = SNZ_MAX;
          missed_n   = 1'b0;
          state_n    = ARMED;
        end
        ARMED: begin
          if (apagar_alarma) missed_n = 1'b0;
          if (tick_1s && now == target) begin
            state_n  = RINGING;
            ring_t_n = '0;
          end
        end
        RINGING: begin
          if (apagar_alarma) begin
            state_n    = ARMED;
            snz_left_n = SNZ_MAX;
          end else if (snooze && snooze_left != 4'd0) begin
            state_n    = SNOOZED;
            snz_left_n = snooze_left - 4'd1;
            snz_t_n    = '0;
          end else if (ring_t >= RING_LIM) begin
            state_n    = ARMED;
            missed_n   = 1'b1;
            snz_left_n = SNZ_MAX;
          end else if (tick_1s) begin
            ring_t_n = sat_inc(ring_t);
          end
        end
        SNOOZED: begin
          if (apagar_alarma) begin
            state_n    = ARMED;
            snz_left_n = SNZ_MAX;
          end else if (snz_t >= SNZ_LIM) begin
            state_n  = RINGING;
            ring_t_n = '0;
          end else if (tick_1s) begin
            snz_t_n = sat_inc(snz_t);
          end
        end
        default: state_n = IDLE;
      endcase
    end
    rem_n = (state_n == ARMED) ? bcd_remaining(target_n, now) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      target      <= '0;
      ring_t      <= '0;
      snz_t       <= '0;
      snooze_left <= '0;
      missed      <= 1'b0;
      rem         <= '0;
      activring   <= 1'b0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      ring_t      <= ring_t_n;
      snz_t       <= snz_t_n;
      snooze_left <= snz_left_n;
      missed      <= missed_n;
      rem         <= rem_n;
      activring   <= (state_n == RINGING);
    end
  end

  assign estado = state;
  assign {hora_1, hora_2, min_1, min_2, seg_1, seg_2} = rem;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: seconds-of-day reference model, directed scenarios
// with literal expectations, then a randomized phase checked every cycle.
module tb_alarm_ring_ctrl;

  localparam int SNZ = 4;
  localparam int RTO = 6;
  localparam int MSN = 2;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       reset, tick_1s, alarma_on, apagar_alarma, snooze;
  logic [7:0] HRTC, MRTC, SRTC, HAL, MAL, SAL;
  logic       activring, missed;
  logic [3:0] hora_1, hora_2, min_1, min_2, seg_1, seg_2, snooze_left;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;
  int now_s  = 0;
  int alm_s  = 0;

  // reference model state (IDLE=0, ARMED=1, RINGING=2, SNOOZED=3)
  int m_st = 0, m_tgt = 0, m_left = 0, m_missed = 0, m_ring = 0, m_snz = 0, m_rem = 0;
  int cur;

  alarm_ring_ctrl #(.SNOOZE_S(SNZ), .RING_TIMEOUT_S(RTO), .MAX_SNOOZE(MSN)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .alarma_on(alarma_on),
    .apagar_alarma(apagar_alarma), .snooze(snooze),
    .HRTC(HRTC), .MRTC(MRTC), .SRTC(SRTC), .HAL(HAL), .MAL(MAL), .SAL(SAL),
    .activring(activring), .hora_1(hora_1), .hora_2(hora_2), .min_1(min_1),
    .min_2(min_2), .seg_1(seg_1), .seg_2(seg_2), .estado(estado),
    .snooze_left(snooze_left), .missed(missed)
  );

  always #5 clk = ~clk;

  function automatic int bcd2s(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return (int'(h[7:4]) * 10 + int'(h[3:0])) * 3600 +
           (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 +
           (int'(s[7:4]) * 10 + int'(s[3:0]));
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk) begin
    cur = bcd2s(HRTC, MRTC, SRTC);
    if (!reset) begin
      m_st = 0; m_tgt = 0; m_left = 0; m_missed = 0; m_ring = 0; m_snz = 0;
    end else if (!alarma_on) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: begin
          m_tgt = bcd2s(HAL, MAL, SAL); m_left = MSN; m_missed = 0; m_st = 1;
        end
        1: begin
          if (apagar_alarma) m_missed = 0;
          if (tick_1s && cur == m_tgt) begin m_st = 2; m_ring = 0; end
        end
        2: begin
          if (apagar_alarma) begin m_st = 1; m_left = MSN; end
          else if (snooze && m_left > 0) begin m_st = 3; m_left = m_left - 1; m_snz = 0; end
          else if (m_ring >= RTO) begin m_st = 1; m_missed = 1; m_left = MSN; end
          else if (tick_1s) m_ring = m_ring + 1;
        end
        default: begin
          if (apagar_alarma) begin m_st = 1; m_left = MSN; end
          else if (m_snz >= SNZ) begin m_st = 2; m_ring = 0; end
          else if (tick_1s) m_snz = m_snz + 1;
        end
      endcase
    end
    m_rem = (m_st == 1) ? (m_tgt - cur + DAY) % DAY : 0;
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int rem_bcd(input int r);
    int h, m, s;
    h = r / 3600; m = (r / 60) % 60; s = r % 60;
    return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
           ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic int dut_rem();
    return int'({hora_1, hora_2, min_1, min_2, seg_1, seg_2});
  endfunction

  task automatic check_model();
    cmp("estado", int'(estado), m_st);
    cmp("activring", int'(activring), (m_st == 2) ? 1 : 0);
    cmp("snooze_left", int'(snooze_left), m_left);
    cmp("missed", int'(missed), m_missed);
    cmp("remaining", dut_rem(), rem_bcd(m_rem));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    check_model();
  endtask

  task automatic set_time(input int s);
    now_s = s;
    HRTC = to_bcd(s / 3600); MRTC = to_bcd((s / 60) % 60); SRTC = to_bcd(s % 60);
  endtask

  task automatic set_alarm(input int s);
    alm_s = s;
    HAL = to_bcd(s / 3600); MAL = to_bcd((s / 60) % 60); SAL = to_bcd(s % 60);
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    set_time((now_s + 1) % DAY);
    cyc();
    tick_1s = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0;
  endtask

  task automatic pulse_apagar();
    apagar_alarma = 1'b1; cyc(); apagar_alarma = 1'b0;
  endtask

  initial begin
    reset = 1'b0; alarma_on = 1'b1; tick_1s = 1'b0; apagar_alarma = 1'b0; snooze = 1'b0;
    set_time(0); set_alarm(0);
    repeat (3) cyc();
    cmp("reset_estado", int'(estado), 0);
    cmp("reset_ring", int'(activring), 0);
    cmp("reset_left", int'(snooze_left), 0);
    cmp("reset_rem", dut_rem(), 0);

    // arm 07:30:00 at 07:29:58, two ticks to ring
    reset = 1'b1;
    set_alarm(7 * 3600 + 30 * 60); set_time(7 * 3600 + 29 * 60 + 58);
    cyc();
    cmp("arm_estado", int'(estado), 1);
    cmp("arm_rem", dut_rem(), 'h000002);
    tick();
    cmp("arm_rem1", dut_rem(), 'h000001);
    tick();
    cmp("ring_estado", int'(estado), 2);
    cmp("ring_act", int'(activring), 1);

    // snooze twice, third snooze ignored
    pulse_snooze();
    cmp("snz1_estado", int'(estado), 3);
    cmp("snz1_left", int'(snooze_left), 1);
    repeat (SNZ) tick();
    cmp("snz1_hold", int'(estado), 3);
    cyc();
    cmp("snz1_back", int'(estado), 2);
    pulse_snooze();
    cmp("snz2_left", int'(snooze_left), 0);
    repeat (SNZ) tick();
    cyc();
    pulse_snooze();
    cmp("snz3_estado", int'(estado), 2);
    cmp("snz3_act", int'(activring), 1);

    // ring timeout -> ARMED with missed, apagar clears it
    repeat (RTO) tick();
    cmp("to_hold", int'(estado), 2);
    cyc();
    cmp("to_estado", int'(estado), 1);
    cmp("to_act", int'(activring), 0);
    cmp("to_missed", int'(missed), 1);
    cmp("to_left", int'(snooze_left), MSN);
    pulse_apagar();
    cmp("apagar_missed", int'(missed), 0);

    // wrap-around remaining time
    alarma_on = 1'b0; cyc();
    cmp("off_estado", int'(estado), 0);
    set_alarm(10); set_time(DAY - 5); alarma_on = 1'b1; cyc();
    cmp("wrap_rem", dut_rem(), 'h000015);
    alarma_on = 1'b0; cyc();
    set_alarm(0); set_time(DAY - 1); alarma_on = 1'b1; cyc();
    cmp("midnight_rem", dut_rem(), 'h000001);
    set_time(0); cyc();
    cmp("exact_rem", dut_rem(), 0);
    cmp("exact_estado", int'(estado), 1);

    // apagar + snooze together
    set_time(DAY - 1); tick();
    apagar_alarma = 1'b1; snooze = 1'b1; cyc(); apagar_alarma = 1'b0; snooze = 1'b0;
    cmp("both_estado", int'(estado), 1);
    cmp("both_left", int'(snooze_left), MSN);

    // reset mid-SNOOZED
    set_time(DAY - 1); tick();
    pulse_snooze();
    reset = 1'b0; cyc();
    cmp("rst_snz_estado", int'(estado), 0);
    cmp("rst_snz_left", int'(snooze_left), 0);
    reset = 1'b1; cyc();

    // timeout to set missed, ring again, drop alarma_on mid-RINGING
    set_time(DAY - 1); tick();
    repeat (RTO) tick();
    cyc();
    set_time(DAY - 1); tick();
    alarma_on = 1'b0; cyc();
    cmp("off_ring_estado", int'(estado), 0);
    cmp("off_ring_act", int'(activring), 0);
    cmp("off_ring_missed", int'(missed), 1);
    cmp("off_ring_left", int'(snooze_left), MSN);
    cmp("off_ring_rem", dut_rem(), 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      tick_1s = ($urandom_range(0, 1) == 1);
      if (tick_1s) set_time((now_s + 1) % DAY);
      if ($urandom_range(0, 59) == 0) set_time((alm_s - int'($urandom_range(0, 3)) + DAY) % DAY);
      if ($urandom_range(0, 49) == 0) set_alarm((now_s + int'($urandom_range(1, 8))) % DAY);
      apagar_alarma = ($urandom_range(0, 39) == 0);
      snooze        = ($urandom_range(0, 9) == 0);
      alarma_on     = ($urandom_range(0, 119) != 0);
      reset         = ($urandom_range(0, 799) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
